alu_cond_wb: RTL and testbench

- Stage directly downstream of the ALU in the SimpleARM execute path.
- Holds the CPSR condition flags (N,Z,C,V) and feeds the registered C back to the ALU carry input.
- Evaluates each instruction's 4-bit condition code against the current flags and conditionally commits the new flags.
- Registers result, destination and write-enable into a one-entry output buffer with valid/ready handshake towards writeback.

---
 rtl/alu_cond_wb.sv | 124 ++++++++++++
 tb/tb_alu_cond_wb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cond_wb.sv
// alu_cond_wb: post-ALU stage that holds the CPSR flags, gates each
// instruction on its ARM condition code and buffers the writeback.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   flush             squashes the buffered and the incoming instruction
//   in_valid/in_ready upstream handshake
//   cond, opcode      condition code and ALU opcode of the instruction
//   set_flags         S bit
//   rd                destination register index
//   alu_result        ALU result
//   alu_flags         ALU flags {N,Z,C,V}
//   shift_carry       shifter carry-out, used by logical opcodes
//   cpsr_flags        registered flags {N,Z,C,V}
//   cpsr_carry        registered C, fed back to the ALU carry input
//   wb_valid/wb_ready downstream handshake
//   wb_data, wb_rd    buffered result and destination
//   wb_we             register write required
module alu_cond_wb #(
   parameter logic [3:0] RESET_FLAGS = 4'h0,
   parameter int         DATA_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        cond,
   input  logic [3:0]        opcode,
   input  logic              set_flags,
   input  logic [3:0]        rd,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_flags,
   input  logic              shift_carry,
   output logic [3:0]        cpsr_flags,
   output logic              cpsr_carry,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic [3:0]        wb_rd,
   output logic              wb_we
);

   logic n, z, c, v;
   logic pass;
   logic accept;
   logic is_cmp;
   logic arith;
   logic upd_en;

   assign n = cpsr_flags[3];
   assign z = cpsr_flags[2];
   assign c = cpsr_flags[1];
   assign v = cpsr_flags[0];

   assign cpsr_carry = cpsr_flags[1];

   assign in_ready = ~wb_valid | wb_ready;
   assign accept   = in_valid & in_ready & ~flush;

   // 8..B are the compare/test ops: they always set flags
   // and never write a register.
   assign is_cmp = (opcode[3:2] == 2'b10);

   // Arithmetic ops take C and V from the adder; logical ops
   // take C from the shifter and leave V alone.
   assign arith = ((opcode >= 4'h2) && (opcode <= 4'h7))
                | (opcode == 4'hA)
                | (opcode == 4'hB);

   always_comb begin
      pass = 1'b0;
      case (cond)
         4'h0: pass = z;
         4'h1: pass = ~z;
         4'h2: pass = c;
         4'h3: pass = ~c;
         4'h4: pass = n;
         4'h5: pass = ~n;
         4'h6: pass = v;
         4'h7: pass = ~v;
         4'h8: pass = c & ~z;
         4'h9: pass = ~c | z;
         4'hA: pass = (n == v);
         4'hB: pass = (n != v);
         4'hC: pass = ~z & (n == v);
         4'hD: pass = z | (n != v);
         4'hE: pass = 1'b1;
         4'hF: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

   assign upd_en = accept & pass & (is_cmp | set_flags);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpsr_flags <= RESET_FLAGS;
         wb_valid   <= 1'b0;
         wb_data    <= '0;
         wb_rd      <= 4'h0;
         wb_we      <= 1'b0;
      end else begin
         if (upd_en) begin
            cpsr_flags[3:2] <= alu_flags[3:2];
            cpsr_flags[1]   <= arith ? alu_flags[1]
                                     : shift_carry;
            if (arith)
               cpsr_flags[0] <= alu_flags[0];
         end
         if (flush) begin
            wb_valid <= 1'b0;
         end else if (accept) begin
            wb_valid <= 1'b1;
            wb_data  <= alu_result;
            wb_rd    <= rd;
            wb_we    <= pass & ~is_cmp;
         end else if (wb_ready) begin
            wb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cond_wb.sv
// tb_alu_cond_wb: directed vectors for alu_cond_wb with
// hand-computed expected flags and writeback fields.
module tb_alu_cond_wb;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  cond;
   logic [3:0]  opcode;
   logic        set_flags;
   logic [3:0]  rd;
   logic [31:0] alu_result;
   logic [3:0]  alu_flags;
   logic        shift_carry;
   logic [3:0]  cpsr_flags;
   logic        cpsr_carry;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [3:0]  wb_rd;
   logic        wb_we;

   int n_chk;
   int n_fail;

   alu_cond_wb #(
      .RESET_FLAGS(4'h0),
      .DATA_W(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .cond(cond),
      .opcode(opcode),
      .set_flags(set_flags),
      .rd(rd),
      .alu_result(alu_result),
      .alu_flags(alu_flags),
      .shift_carry(shift_carry),
      .cpsr_flags(cpsr_flags),
      .cpsr_carry(cpsr_carry),
      .wb_valid(wb_valid),
      .wb_ready(wb_ready),
      .wb_data(wb_data),
      .wb_rd(wb_rd),
      .wb_we(wb_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
      end
   endtask

   task automatic drv(input logic        v,
                      input logic [3:0]  cc,
                      input logic [3:0]  op,
                      input logic        s,
                      input logic [3:0]  d,
                      input logic [31:0] res,
                      input logic [3:0]  fl,
                      input logic        sc);
      in_valid    = v;
      cond        = cc;
      opcode      = op;
      set_flags   = s;
      rd          = d;
      alu_result  = res;
      alu_flags   = fl;
      shift_carry = sc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] pass_tbl;
      n_chk  = 0;
      n_fail = 0;
      reset    = 1'b1;
      flush    = 1'b0;
      wb_ready = 1'b1;
      drv(1'b0, 4'hE, 4'h0, 1'b0, 4'h0, 32'h0,
          4'h0, 1'b0);
      #12;
      check("rst_flags", cpsr_flags, 4'h0);
      check("rst_valid", wb_valid, 1'b0);
      check("rst_data", wb_data, 32'h0);
      check("rst_rd", wb_rd, 4'h0);
      check("rst_we", wb_we, 1'b0);
      check("rst_ready", in_ready, 1'b1);
      tick();
      reset = 1'b0;

      // ADD, AL, S=1 -> flags 0110
      drv(1'b1, 4'hE, 4'h4, 1'b1, 4'h1, 32'h0,
          4'b0110, 1'b0);
      tick();
      check("add_flags", cpsr_flags, 4'b0110);
      check("add_carry", cpsr_carry, 1'b1);
      check("add_valid", wb_valid, 1'b1);
      check("add_we", wb_we, 1'b1);
      check("add_data", wb_data, 32'h0);
      check("add_rd", wb_rd, 4'h1);

      // NE with Z=1 fails: no write, no flag change
      drv(1'b1, 4'h1, 4'h4, 1'b1, 4'h2, 32'h5,
          4'b1000, 1'b0);
      tick();
      check("ne_we", wb_we, 1'b0);
      check("ne_flags", cpsr_flags, 4'b0110);
      check("ne_data", wb_data, 32'h5);
      check("ne_valid", wb_valid, 1'b1);

      // EQ with Z=1 passes
      drv(1'b1, 4'h0, 4'h4, 1'b0, 4'h3, 32'h7,
          4'b1000, 1'b0);
      tick();
      check("eq_we", wb_we, 1'b1);
      check("eq_flags", cpsr_flags, 4'b0110);

      // CMP with S=0 still sets flags
      drv(1'b1, 4'hE, 4'hA, 1'b0, 4'h4, 32'h9,
          4'b1001, 1'b0);
      tick();
      check("cmp_flags", cpsr_flags, 4'b1001);
      check("cmp_we", wb_we, 1'b0);

      // ORR S=1: C from shifter, V held
      drv(1'b1, 4'hE, 4'hC, 1'b1, 4'h5, 32'h1,
          4'b0000, 1'b1);
      tick();
      check("orr_flags", cpsr_flags, 4'b0011);
      check("orr_we", wb_we, 1'b1);

      // Back-to-back: CMP sets Z, next EQ sees it
      drv(1'b1, 4'hE, 4'hA, 1'b0, 4'h6, 32'h0,
          4'b0100, 1'b1);
      tick();
      check("b2b_flags", cpsr_flags, 4'b0100);
      drv(1'b1, 4'h0, 4'h4, 1'b0, 4'h7, 32'h55,
          4'b1111, 1'b1);
      tick();
      check("b2b_we", wb_we, 1'b1);
      check("b2b_data", wb_data, 32'h55);

      // All 16 codes against N=0 Z=1 C=0 V=0
      pass_tbl = 16'h66A9;
      for (int i = 0; i < 16; i++) begin
         drv(1'b1, i[3:0], 4'h0, 1'b0, 4'h8,
             32'(i), 4'b1111, 1'b1);
         tick();
         check($sformatf("cond%0d", i), wb_we,
               pass_tbl[i]);
      end
      check("tbl_flags", cpsr_flags, 4'b0100);

      // Flush dominates accept
      flush = 1'b1;
      drv(1'b1, 4'hE, 4'h4, 1'b1, 4'h9, 32'hDEAD,
          4'b1111, 1'b1);
      tick();
      flush = 1'b0;
      check("fl_valid", wb_valid, 1'b0);
      check("fl_flags", cpsr_flags, 4'b0100);

      // Backpressure
      wb_ready = 1'b0;
      drv(1'b1, 4'hE, 4'h0, 1'b0, 4'hA, 32'hA0,
          4'h0, 1'b0);
      tick();
      check("bp_valid", wb_valid, 1'b1);
      check("bp_data0", wb_data, 32'hA0);
      drv(1'b1, 4'hE, 4'h0, 1'b0, 4'hB, 32'hA1,
          4'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("bp_rdy", in_ready, 1'b0);
         tick();
         check("bp_hold", wb_data, 32'hA0);
         check("bp_rd", wb_rd, 4'hA);
      end
      wb_ready = 1'b1;
      #1;
      check("bp_rdy1", in_ready, 1'b1);
      tick();
      check("bp_data1", wb_data, 32'hA1);
      check("bp_v1", wb_valid, 1'b1);
      drv(1'b1, 4'hE, 4'h0, 1'b0, 4'hC, 32'hA2,
          4'h0, 1'b0);
      tick();
      check("bp_data2", wb_data, 32'hA2);
      check("bp_v2", wb_valid, 1'b1);
      drv(1'b0, 4'hE, 4'h0, 1'b0, 4'h0, 32'h0,
          4'h0, 1'b0);
      tick();
      check("bp_drain", wb_valid, 1'b0);
      check("bp_keep", wb_data, 32'hA2);

      // Async reset in the middle of a stall
      wb_ready = 1'b0;
      drv(1'b1, 4'hE, 4'h0, 1'b0, 4'hD, 32'hB0,
          4'h0, 1'b0);
      tick();
      check("st_valid", wb_valid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("ar_valid", wb_valid, 1'b0);
      check("ar_flags", cpsr_flags, 4'h0);
      check("ar_data", wb_data, 32'h0);
      check("ar_rd", wb_rd, 4'h0);
      check("ar_we", wb_we, 1'b0);
      tick();
      reset = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
